// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   pc_state_e     - controller FSM states (RUN / DRAIN / REDIRECT)
//   STG_*          - bit index of each stage register in the stall/flush vectors
//   NUM_STAGE_REGS - number of pipeline stage registers (IF_ID .. MEM_WB)
//   stage_mask_t   - one bit per stage register
//   stg_bit()      - builds a one-hot mask for a single stage register
package pipe_ctrl_pkg;

    localparam int NUM_STAGE_REGS = 4;

    localparam int STG_IF_ID  = 0;
    localparam int STG_ID_EX  = 1;
    localparam int STG_EX_MEM = 2;
    localparam int STG_MEM_WB = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } pc_state_e;

    typedef logic [NUM_STAGE_REGS-1:0] stage_mask_t;

    function automatic stage_mask_t stg_bit(input int idx);
        return stage_mask_t'(1) << idx;
    endfunction

    // Everything upstream of MEM_WB, i.e. the registers a trap throws away
    // while the outstanding memory access is allowed to finish.
    localparam stage_mask_t MASK_NONE     = '0;
    localparam stage_mask_t MASK_ALL      = '1;
    localparam stage_mask_t MASK_FRONT3   = stg_bit(STG_IF_ID) | stg_bit(STG_ID_EX) | stg_bit(STG_EX_MEM);
    localparam stage_mask_t MASK_FRONT2   = stg_bit(STG_IF_ID) | stg_bit(STG_ID_EX);

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
// Bundles the hazard-detection inputs coming from the pipeline stages and the
// stall/flush/redirect controls going back to them.
//   master modport : pipeline side (drives stage status, receives controls)
//   slave modport  : hazard controller (reads stage status, drives controls)
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int PC_W       = 32
);

    logic                  id_valid;
    logic                  id_rs1_en;
    logic                  id_rs2_en;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;

    logic                  ex_valid;
    logic                  ex_is_load;
    logic [REG_ADDR_W-1:0] ex_rw_addr;
    logic                  ex_busy;
    logic                  ex_br_taken;
    logic [PC_W-1:0]       ex_br_target;

    logic                  mem_busy;

    logic                  wb_excp;
    logic                  wb_ertn;
    logic [PC_W-1:0]       wb_excp_target;
    logic [PC_W-1:0]       wb_ertn_target;

    logic [3:0]            stall;
    logic [3:0]            flush;
    logic                  redirect_valid;
    logic [PC_W-1:0]       redirect_pc;

    modport master (
        output id_valid, id_rs1_en, id_rs2_en, id_rs1_addr, id_rs2_addr,
        output ex_valid, ex_is_load, ex_rw_addr, ex_busy, ex_br_taken, ex_br_target,
        output mem_busy,
        output wb_excp, wb_ertn, wb_excp_target, wb_ertn_target,
        input  stall, flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  id_valid, id_rs1_en, id_rs2_en, id_rs1_addr, id_rs2_addr,
        input  ex_valid, ex_is_load, ex_rw_addr, ex_busy, ex_br_taken, ex_br_target,
        input  mem_busy,
        input  wb_excp, wb_ertn, wb_excp_target, wb_ertn_target,
        output stall, flush, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/pipe_hazard_ctrl_perf.sv
// pipe_hazard_perf
// Hazard performance counters, only instantiated when PIPE_HAZARD_PERF_EN
// is defined. All counters wrap modulo 2^CNT_W.
//   clk, rst     : clock, async active-high reset
//   stall_evt    : some stage register is stalled this cycle
//   redirect_evt : a branch or exception redirect is issued this cycle
//   lu_evt       : a load-use stall is applied this cycle
//   stall_cyc, flush_cnt, lu_cnt : counter values
module pipe_hazard_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_evt,
    input  logic             redirect_evt,
    input  logic             lu_evt,
    output logic [CNT_W-1:0] stall_cyc,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] lu_cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cyc <= '0;
            flush_cnt <= '0;
            lu_cnt    <= '0;
        end else begin
            if (stall_evt)    stall_cyc <= stall_cyc + CNT_W'(1);
            if (redirect_evt) flush_cnt <= flush_cnt + CNT_W'(1);
            if (lu_evt)       lu_cnt    <= lu_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush/redirect controller for the IF_ID, ID_EX, EX_MEM and
// MEM_WB stage registers. Resolves load-use hazards, multi-cycle EX ops,
// memory waits and taken branches, and sequences exception/ertn redirects
// through RUN -> (DRAIN) -> REDIRECT so an outstanding memory access
// completes before fetch is restarted.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   hz       : pipe_hazard_ctrl_if.slave (stage status in, stall/flush/redirect out)
//   perf_stall_cyc, perf_flush_cnt, perf_lu_cnt : counters, only when the
//              macro PIPE_HAZARD_PERF_EN is defined
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int PC_W       = 32,
    parameter int CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_hazard_ctrl_if.slave      hz
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]       perf_stall_cyc,
    output logic [CNT_W-1:0]       perf_flush_cnt,
    output logic [CNT_W-1:0]       perf_lu_cnt
`endif
);

    localparam logic [1:0] S_RUN      = RUN;
    localparam logic [1:0] S_DRAIN    = DRAIN;
    localparam logic [1:0] S_REDIRECT = REDIRECT;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [PC_W-1:0]       tgt_q;

    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  trap;
    logic                  load_use;

    stage_mask_t           hold_c;
    stage_mask_t           clear_c;
    logic                  redir_c;
    logic [PC_W-1:0]       redir_pc_c;
    logic                  latch_tgt;
    logic                  lu_sel;

    assign ex_rd = hz.ex_rw_addr;
    assign trap  = hz.wb_excp | hz.wb_ertn;

    // r0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = hz.id_valid & hz.ex_valid & hz.ex_is_load & (ex_rd != '0) &
                      ((hz.id_rs1_en & (hz.id_rs1_addr == ex_rd)) |
                       (hz.id_rs2_en & (hz.id_rs2_addr == ex_rd)));

    // Hazard resolution and next-state selection. In RUN the if/else chain
    // encodes the priority order; DRAIN deliberately ignores new traps.
    always_comb begin
        hold_c     = MASK_NONE;
        clear_c    = MASK_NONE;
        redir_c    = 1'b0;
        redir_pc_c = '0;
        state_d    = state_q;
        latch_tgt  = 1'b0;
        lu_sel     = 1'b0;
        case (state_q)
            S_RUN: begin
                if (trap) begin
                    latch_tgt = 1'b1;
                    if (hz.mem_busy) begin
                        clear_c = MASK_FRONT3;
                        hold_c  = stg_bit(STG_MEM_WB);
                        state_d = S_DRAIN;
                    end else begin
                        clear_c = MASK_ALL;
                        state_d = S_REDIRECT;
                    end
                end else if (hz.mem_busy) begin
                    // WB gets a bubble while everything upstream (including
                    // a resolved branch in EX) waits in place.
                    hold_c  = MASK_FRONT3;
                    clear_c = stg_bit(STG_MEM_WB);
                end else if (hz.ex_valid & hz.ex_br_taken) begin
                    clear_c    = MASK_FRONT2;
                    redir_c    = 1'b1;
                    redir_pc_c = hz.ex_br_target;
                end else if (hz.ex_busy) begin
                    hold_c  = MASK_FRONT2;
                    clear_c = stg_bit(STG_EX_MEM);
                end else if (load_use) begin
                    hold_c  = stg_bit(STG_IF_ID);
                    clear_c = stg_bit(STG_ID_EX);
                    lu_sel  = 1'b1;
                end
            end
            S_DRAIN: begin
                clear_c = MASK_FRONT3;
                hold_c  = stg_bit(STG_MEM_WB);
                if (!hz.mem_busy) begin
                    state_d = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                clear_c    = MASK_ALL;
                redir_c    = 1'b1;
                redir_pc_c = tgt_q;
                state_d    = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Controller state and the latched trap target; wb_excp wins over
    // wb_ertn when both commit together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (latch_tgt) begin
                tgt_q <= hz.wb_excp ? hz.wb_excp_target : hz.wb_ertn_target;
            end
        end
    end

    // Outputs are forced quiet while reset is held so a reset pulse silences
    // the pipeline immediately, even with mem_busy still asserted.
    // Flush overrides stall on any bit where both would be set.
    assign hz.stall          = rst ? 4'b0000 : (hold_c & ~clear_c);
    assign hz.flush          = rst ? 4'b0000 : clear_c;
    assign hz.redirect_valid = rst ? 1'b0 : redir_c;
    assign hz.redirect_pc    = rst ? '0 : redir_pc_c;

`ifdef PIPE_HAZARD_PERF_EN
    pipe_hazard_perf #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst          (rst),
        .stall_evt    (~rst & (|(hold_c & ~clear_c))),
        .redirect_evt (~rst & redir_c),
        .lu_evt       (~rst & lu_sel),
        .stall_cyc    (perf_stall_cyc),
        .flush_cnt    (perf_flush_cnt),
        .lu_cnt       (perf_lu_cnt)
    );
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. A behavioural model classifies each
// cycle into a hazard cause and predicts stall/flush/redirect (and counters
// when PIPE_HAZARD_PERF_EN is defined); a negedge process compares every
// cycle, and the stimulus adds hand-computed literal checks.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .PC_W(32)) bus();

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_lu_cnt;
`endif

    pipe_hazard_ctrl #(
        .REG_ADDR_W (5),
        .PC_W       (32),
        .CNT_W      (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hz             (bus)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_lu_cnt    (perf_lu_cnt)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycle causes, in the order the controller is expected to prefer them.
    localparam int C_NONE      = 0;
    localparam int C_TRAP_NOW  = 1;
    localparam int C_TRAP_WAIT = 2;
    localparam int C_DRAIN     = 3;
    localparam int C_REDIRECT  = 4;
    localparam int C_MEMWAIT   = 5;
    localparam int C_BRANCH    = 6;
    localparam int C_EXBUSY    = 7;
    localparam int C_LOADUSE   = 8;

    // Model state: 0 = normal, 1 = waiting for memory, 2 = redirect due.
    int          m_phase = 0;
    logic [31:0] m_tgt   = '0;
    int unsigned m_stall_cyc = 0;
    int unsigned m_redirs    = 0;
    int unsigned m_lu        = 0;

    function automatic int model_cause();
        logic lu;
        lu = bus.id_valid && bus.ex_valid && bus.ex_is_load && (bus.ex_rw_addr != 0) &&
             ((bus.id_rs1_en && bus.id_rs1_addr == bus.ex_rw_addr) ||
              (bus.id_rs2_en && bus.id_rs2_addr == bus.ex_rw_addr));
        if (m_phase == 2) return C_REDIRECT;
        if (m_phase == 1) return C_DRAIN;
        if (bus.wb_excp || bus.wb_ertn) return bus.mem_busy ? C_TRAP_WAIT : C_TRAP_NOW;
        if (bus.mem_busy) return C_MEMWAIT;
        if (bus.ex_valid && bus.ex_br_taken) return C_BRANCH;
        if (bus.ex_busy) return C_EXBUSY;
        if (lu) return C_LOADUSE;
        return C_NONE;
    endfunction

    // Which registers each cause wants held and which it wants cleared.
    task automatic cause_masks(input int c, output logic [3:0] hold, output logic [3:0] clear);
        case (c)
            C_TRAP_NOW:  begin hold = 4'b0000; clear = 4'b1111; end
            C_TRAP_WAIT: begin hold = 4'b1000; clear = 4'b0111; end
            C_DRAIN:     begin hold = 4'b1000; clear = 4'b0111; end
            C_REDIRECT:  begin hold = 4'b0000; clear = 4'b1111; end
            C_MEMWAIT:   begin hold = 4'b0111; clear = 4'b1000; end
            C_BRANCH:    begin hold = 4'b0000; clear = 4'b0011; end
            C_EXBUSY:    begin hold = 4'b0011; clear = 4'b0100; end
            C_LOADUSE:   begin hold = 4'b0001; clear = 4'b0010; end
            default:     begin hold = 4'b0000; clear = 4'b0000; end
        endcase
    endtask

    // Per-cycle comparison against the model, then model advance.
    always @(negedge clk) begin : compare_proc
        int          c;
        logic [3:0]  hold;
        logic [3:0]  clear;
        logic [3:0]  exp_stall;
        logic        exp_rv;
        logic [31:0] exp_pc;
        if (rst) begin
            check_output("rst_stall", 32'(bus.stall), 32'h0);
            check_output("rst_flush", 32'(bus.flush), 32'h0);
            check_output("rst_redirect_valid", 32'(bus.redirect_valid), 32'h0);
            check_output("rst_redirect_pc", bus.redirect_pc, 32'h0);
            m_phase     = 0;
            m_tgt       = '0;
            m_stall_cyc = 0;
            m_redirs    = 0;
            m_lu        = 0;
        end else begin
            c = model_cause();
            cause_masks(c, hold, clear);
            exp_stall = hold & ~clear;
            exp_rv    = (c == C_BRANCH) || (c == C_REDIRECT);
            exp_pc    = (c == C_BRANCH) ? bus.ex_br_target : m_tgt;
            check_output("cyc_stall", 32'(bus.stall), 32'(exp_stall));
            check_output("cyc_flush", 32'(bus.flush), 32'(clear));
            check_output("cyc_redirect_valid", 32'(bus.redirect_valid), 32'(exp_rv));
            if (exp_rv) check_output("cyc_redirect_pc", bus.redirect_pc, exp_pc);
`ifdef PIPE_HAZARD_PERF_EN
            check_output("cyc_perf_stall", perf_stall_cyc, m_stall_cyc);
            check_output("cyc_perf_flush", perf_flush_cnt, m_redirs);
            check_output("cyc_perf_lu", perf_lu_cnt, m_lu);
`endif
            if (exp_stall != 0) m_stall_cyc++;
            if (exp_rv) m_redirs++;
            if (c == C_LOADUSE) m_lu++;
            case (c)
                C_TRAP_NOW:  begin m_phase = 2; m_tgt = bus.wb_excp ? bus.wb_excp_target : bus.wb_ertn_target; end
                C_TRAP_WAIT: begin m_phase = 1; m_tgt = bus.wb_excp ? bus.wb_excp_target : bus.wb_ertn_target; end
                C_DRAIN:     if (!bus.mem_busy) m_phase = 2;
                C_REDIRECT:  m_phase = 0;
                default:     ;
            endcase
        end
    end

    task automatic idle_inputs();
        bus.id_valid       = 1'b0;
        bus.id_rs1_en      = 1'b0;
        bus.id_rs2_en      = 1'b0;
        bus.id_rs1_addr    = '0;
        bus.id_rs2_addr    = '0;
        bus.ex_valid       = 1'b0;
        bus.ex_is_load     = 1'b0;
        bus.ex_rw_addr     = '0;
        bus.ex_busy        = 1'b0;
        bus.ex_br_taken    = 1'b0;
        bus.ex_br_target   = '0;
        bus.mem_busy       = 1'b0;
        bus.wb_excp        = 1'b0;
        bus.wb_ertn        = 1'b0;
        bus.wb_excp_target = '0;
        bus.wb_ertn_target = '0;
    endtask

    // Advance to just after the next rising edge and return to idle inputs;
    // the caller then sets up the cycle's specific stimulus.
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic load_use_setup(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic rs2_en);
        bus.ex_valid    = 1'b1;
        bus.ex_is_load  = 1'b1;
        bus.ex_rw_addr  = rd;
        bus.id_valid    = 1'b1;
        bus.id_rs1_en   = 1'b1;
        bus.id_rs1_addr = rs1;
        bus.id_rs2_en   = rs2_en;
        bus.id_rs2_addr = rs2;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_stall", 32'(bus.stall), 32'h0);
        check_output("reset_flush", 32'(bus.flush), 32'h0);
        check_output("reset_redirect_valid", 32'(bus.redirect_valid), 32'h0);
`ifdef PIPE_HAZARD_PERF_EN
        check_output("reset_perf_stall", perf_stall_cyc, 32'h0);
        check_output("reset_perf_lu", perf_lu_cnt, 32'h0);
`endif
        #1 rst = 1'b0;

        // lw r5 in EX, add r6,r5,r1 in ID
        apply_stimulus();
        load_use_setup(5'd5, 5'd5, 5'd1, 1'b1);
        #1;
        check_output("lu_stall", 32'(bus.stall), 32'h1);
        check_output("lu_flush", 32'(bus.flush), 32'h2);
        // next cycle the add has moved on, EX holds a non-load
        apply_stimulus();
        bus.ex_valid = 1'b1; bus.ex_rw_addr = 5'd6;
        bus.id_valid = 1'b1; bus.id_rs1_en = 1'b1; bus.id_rs1_addr = 5'd6;
        #1;
        check_output("lu_after_stall", 32'(bus.stall), 32'h0);
        // load to r0 never stalls
        apply_stimulus();
        load_use_setup(5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        check_output("lu_r0_stall", 32'(bus.stall), 32'h0);
        // rs2 match only counts when rs2 is enabled
        apply_stimulus();
        load_use_setup(5'd7, 5'd3, 5'd7, 1'b0);
        #1;
        check_output("lu_rs2_off", 32'(bus.stall), 32'h0);
        apply_stimulus();
        load_use_setup(5'd7, 5'd3, 5'd7, 1'b1);
        #1;
        check_output("lu_rs2_on", 32'(bus.stall), 32'h1);

        // taken branch, same-cycle redirect
        apply_stimulus();
        bus.ex_valid = 1'b1; bus.ex_br_taken = 1'b1; bus.ex_br_target = 32'h1C000040;
        #1;
        check_output("br_valid", 32'(bus.redirect_valid), 32'h1);
        check_output("br_pc", bus.redirect_pc, 32'h1C000040);
        check_output("br_flush", 32'(bus.flush), 32'h3);

        // branch held behind three mem_busy cycles
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            bus.ex_valid = 1'b1; bus.ex_br_taken = 1'b1; bus.ex_br_target = 32'h1C000080;
            bus.mem_busy = 1'b1;
            #1;
            check_output("brmem_stall", 32'(bus.stall), 32'h7);
            check_output("brmem_redirect", 32'(bus.redirect_valid), 32'h0);
        end
        apply_stimulus();
        bus.ex_valid = 1'b1; bus.ex_br_taken = 1'b1; bus.ex_br_target = 32'h1C000080;
        #1;
        check_output("brmem_release_pc", bus.redirect_pc, 32'h1C000080);
        check_output("brmem_release_valid", 32'(bus.redirect_valid), 32'h1);

        // ex_busy outranks load-use
        apply_stimulus();
        load_use_setup(5'd9, 5'd9, 5'd2, 1'b1);
        bus.ex_busy = 1'b1;
        #1;
        check_output("exbusy_stall", 32'(bus.stall), 32'h3);
        check_output("exbusy_flush", 32'(bus.flush), 32'h4);

        // exception with idle MEM and a simultaneous branch
        apply_stimulus();
        bus.wb_excp = 1'b1; bus.wb_excp_target = 32'h1C008000;
        bus.ex_valid = 1'b1; bus.ex_br_taken = 1'b1; bus.ex_br_target = 32'h1C000040;
        #1;
        check_output("excp_flush", 32'(bus.flush), 32'hF);
        check_output("excp_no_branch", 32'(bus.redirect_valid), 32'h0);
        apply_stimulus();
        #1;
        check_output("excp_redirect_valid", 32'(bus.redirect_valid), 32'h1);
        check_output("excp_redirect_pc", bus.redirect_pc, 32'h1C008000);
        apply_stimulus();
        #1;
        check_output("excp_one_shot", 32'(bus.redirect_valid), 32'h0);

        // exception + ertn together under mem_busy, ertn during DRAIN ignored
        apply_stimulus();
        bus.wb_excp = 1'b1; bus.wb_excp_target = 32'h1C008100;
        bus.wb_ertn = 1'b1; bus.wb_ertn_target = 32'h1C00A000;
        bus.mem_busy = 1'b1;
        #1;
        check_output("drain_enter_stall", 32'(bus.stall), 32'h8);
        check_output("drain_enter_flush", 32'(bus.flush), 32'h7);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            bus.mem_busy = 1'b1;
            bus.wb_ertn = 1'b1; bus.wb_ertn_target = 32'h1C00B000;
            #1;
            check_output("drain_stall", 32'(bus.stall), 32'h8);
            check_output("drain_no_redirect", 32'(bus.redirect_valid), 32'h0);
        end
        apply_stimulus();
        #1;
        check_output("drain_last_stall", 32'(bus.stall), 32'h8);
        check_output("drain_last_redirect", 32'(bus.redirect_valid), 32'h0);
        apply_stimulus();
        #1;
        check_output("drain_redirect_valid", 32'(bus.redirect_valid), 32'h1);
        check_output("drain_redirect_pc", bus.redirect_pc, 32'h1C008100);
        apply_stimulus();
        #1;
        check_output("drain_one_shot", 32'(bus.redirect_valid), 32'h0);

        // async reset pulse in the middle of DRAIN
        apply_stimulus();
        bus.wb_excp = 1'b1; bus.wb_excp_target = 32'h1C00C000;
        bus.mem_busy = 1'b1;
        apply_stimulus();
        bus.mem_busy = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_output("midrst_stall", 32'(bus.stall), 32'h0);
        check_output("midrst_flush", 32'(bus.flush), 32'h0);
        check_output("midrst_redirect", 32'(bus.redirect_valid), 32'h0);
`ifdef PIPE_HAZARD_PERF_EN
        check_output("midrst_perf_flush", perf_flush_cnt, 32'h0);
        check_output("midrst_perf_stall", perf_stall_cyc, 32'h0);
`endif
        @(negedge clk);
        #2 rst = 1'b0;
        apply_stimulus();
        #1;
        check_output("postrst_redirect", 32'(bus.redirect_valid), 32'h0);
        check_output("postrst_flush", 32'(bus.flush), 32'h0);
        apply_stimulus();
        #1;
        check_output("postrst_redirect2", 32'(bus.redirect_valid), 32'h0);

        // plain ertn with idle MEM
        apply_stimulus();
        bus.wb_ertn = 1'b1; bus.wb_ertn_target = 32'h1C00D000;
        #1;
        check_output("ertn_flush", 32'(bus.flush), 32'hF);
        apply_stimulus();
        #1;
        check_output("ertn_redirect_pc", bus.redirect_pc, 32'h1C00D000);

        apply_stimulus();
        apply_stimulus();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush/redirect controller for the four-register in-order pipeline (IF_ID, ID_EX, EX_MEM, MEM_WB). It sequences every stage register's `stall` and `flush` inputs:
- resolves load-use hazards, multi-cycle EX ops, memory waits and taken branches;
- runs a small FSM that drains an outstanding memory access before committing an exception/ertn redirect to the fetch unit.

## Interface
Parameters:
- `REG_ADDR_W`, 5, register-file address width
- `PC_W`, 32, PC / target address width
- `CNT_W`, 32, performance counter width

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  asynchronous, active-high reset
- `id_valid`  in  1  ID holds a valid instruction
- `id_rs1_en`, `id_rs2_en`  in  1  source operand used
- `id_rs1_addr`, `id_rs2_addr`  in  REG_ADDR_W  source registers
- `ex_valid`  in  1  EX holds a valid instruction
- `ex_is_load`  in  1  EX instruction is a load
- `ex_rw_addr`  in  REG_ADDR_W  EX destination register
- `ex_busy`  in  1  multi-cycle EX op (div/mul) not finished
- `ex_br_taken`  in  1  EX resolved a taken branch/jump
- `ex_br_target`  in  PC_W  branch target
- `mem_busy`  in  1  MEM data access outstanding
- `wb_excp`, `wb_ertn`  in  1  WB commits an exception / ertn
- `wb_excp_target`, `wb_ertn_target`  in  PC_W  eentry / era
- `stall`  out  4  hold register i (bit 0=IF_ID, 1=ID_EX, 2=EX_MEM, 3=MEM_WB)
- `flush`  out  4  clear register i to invalid at the next edge
- `redirect_valid`  out  1  fetch must restart at `redirect_pc`
- `redirect_pc`  out  PC_W  restart address
- `perf_stall_cyc`, `perf_flush_cnt`, `perf_lu_cnt`  out  CNT_W  counters; present only with the macro

## Operation
- FSM states (`pc_state_e`): `RUN`, `DRAIN`, `REDIRECT`. Reset state: `RUN`.
- Resolution priority in `RUN`, highest first: exception/ertn > mem_busy > branch > ex_busy > load-use.
- **Exception / ertn** (`wb_excp | wb_ertn`):
  - Latch the target into `tgt_q`; `wb_excp` wins when both are set.
  - If `mem_busy=0`: `flush=4'b1111` this cycle, next state `REDIRECT`.
  - If `mem_busy=1`: `flush=4'b0111`, `stall=4'b1000`, next state `DRAIN`.
- **DRAIN**:
  - Outputs `flush=4'b0111`, `stall=4'b1000`.
  - Leave for `REDIRECT` in the first cycle `mem_busy=0`.
  - New `wb_excp`/`wb_ertn` is ignored.
- **REDIRECT** (exactly one cycle):
  - Outputs `flush=4'b1111`, `redirect_valid=1`, `redirect_pc=tgt_q`.
  - Then `RUN`.
- **mem_busy** (RUN): `stall=4'b0111`, `flush=4'b1000`. This inserts a WB bubble; any branch in EX is held, not lost.
- **Taken branch** (`ex_valid & ex_br_taken`, RUN): `flush=4'b0011`, `redirect_valid=1`, `redirect_pc=ex_br_target`, combinational in the same cycle.
- **ex_busy**: `stall=4'b0011`, `flush=4'b0100`.
- **Load-use**:
  - Condition: `id_valid & ex_valid & ex_is_load & ex_rw_addr!=0`, plus a match on an enabled rs1 or rs2.
  - Response: `stall=4'b0001`, `flush=4'b0010`.
  - Lasts one cycle; MEM→ID forwarding covers the rest.
- `stall` and `flush` are never both set on the same bit. If a rule would set both, flush wins.
- All outputs other than `tgt_q`-derived values are combinational from inputs and state.

## Timing
- Reset (async assert, sync use after deassert):
  - `stall=0`, `flush=0`, `redirect_valid=0`, `redirect_pc=0`;
  - `tgt_q=0`, state `RUN`, counters 0.
- Branch redirect latency: 0 cycles (same cycle as `ex_br_taken`).
- Exception redirect latency:
  - 1 cycle after `wb_excp` when `mem_busy=0`;
  - otherwise 1 cycle after `mem_busy` falls.
- `redirect_valid` is high for exactly one cycle per event.
- Reset mid-DRAIN/REDIRECT: back to `RUN` with no redirect issued.
- Branch and exception in the same cycle: the exception wins and the branch redirect is suppressed.

## Configuration
- `PIPE_HAZARD_PERF_EN` defined:
  - `perf_stall_cyc` counts cycles with any `stall` bit set.
  - `perf_flush_cnt` counts branch and exception redirects.
  - `perf_lu_cnt` counts load-use stalls.
  - All counters wrap modulo 2^CNT_W.
- Undefined: the counter ports and logic are absent.

## Structure
- `pipe_ctrl_pkg`:
  - `pc_state_e` enum;
  - stage index constants `STG_IF_ID`=0 .. `STG_MEM_WB`=3;
  - `NUM_STAGE_REGS`=4.
- Sub-module `pipe_hazard_perf`: the three counters, instantiated under the macro.

## Test plan
- Load-use: EX `lw r5`, ID `add r6,r5,r1` → one cycle of `stall=0001`, `flush=0010`; `ex_rw_addr=0` → no stall.
- Branch: `ex_br_taken=1`, target `0x1C000040` → same-cycle `redirect_pc=0x1C000040`, `flush=0011`.
- Branch under mem_busy: 3 busy cycles → `stall=0111` for 3 cycles, then the branch redirect fires.
- Exception, idle MEM: `wb_excp=1`, eentry `0x1C008000` → `flush=1111`, next cycle `redirect_valid=1`, pc `0x1C008000`.
- Exception with `mem_busy` for 4 cycles → DRAIN for 4 cycles (`stall=1000`), then REDIRECT; `wb_ertn` during DRAIN is ignored.
- Async `rst` pulse mid-DRAIN → outputs 0 immediately, no redirect; with the macro on, counters read 0.
